i2c_slave_regfile: RTL and testbench
====================================

# i2c_slave_regfile

Synthesizable, parameterised I2C target with an internal byte register file, sitting on the board-side I2C bus opposite the APB I2C master. Oversamples SCL/SDA on the system clock, decodes start/stop/repeated start, supports multi-byte write and read with auto-incrementing pointer, configurable wrap or NACK at the end of the register file. Also exposes a local port so system logic can read/write the same registers and observe I2C writes.

## Interface
- I2C_ADR, 7'h10, 7-bit target address.
- MEM_DEPTH, 16, number of 8-bit registers (2..256).
- WRAP, 1, 1: pointer wraps to 0 after MEM_DEPTH-1; 0: accesses past the end are refused.
- FILT, 2, input glitch-filter length in clk cycles (stable samples required to accept a level change).
- clk  in  1  system clock; must be ≥ 16× SCL frequency.
- rst  in  1  reset; synchronous, active-high.
- scl_i  in  1  SCL pad input.
- sda_i  in  1  SDA pad input.
- sda_oe  out  1  1 = drive SDA low, 0 = release.
- loc_addr  in  8  local register index.
- loc_wdata  in  8  local write data.
- loc_we  in  1  local write strobe.
- loc_rdata  out  8  register[loc_addr], registered.
- wr_valid  out  1  one-cycle pulse per accepted I2C data byte.
- wr_addr  out  8  register index of that byte.
- wr_data  out  8  the byte written.
- loc_coll  out  1  one-cycle pulse: local write dropped due to same-cycle I2C write.
- busy  out  1  high from own-address ACK until stop or start.

## Operation
- Inputs: 2-FF synchroniser, then FILT-sample filter; scl_rise/scl_fall/sda_rise/sda_fall are single-cycle events from filtered levels.
- Start/repeated start: sda_fall while SCL high → DEV_ADDR, bit counter = 0, sda_oe = 0. Allowed in any state.
- Stop: sda_rise while SCL high → IDLE, sda_oe = 0, busy = 0. Start and stop never both seen in one cycle (filtered SDA changes once per cycle).
- Bits sampled on scl_rise, MSB first; sda_oe updated on the cycle after scl_fall.
- States: IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
- DEV_ADDR: after 8 bits, if byte[7:1] == I2C_ADR → DEV_ACK (drive low for ACK slot), latch rw = byte[0]; else → IGNORE (released until next start/stop).
- DEV_ACK: rw=0 → PTR; rw=1 → RD, shift register preloaded with reg[ptr] (ptr retained from last transaction).
- PTR: 8 bits → ptr. ACK only if value < MEM_DEPTH, then → PTR_ACK → WR; else NACK → IGNORE.
- WR: 8 bits → WR_ACK. Byte accepted if ptr < MEM_DEPTH: reg[ptr] written, wr_valid pulse, ACK, ptr+1 (WRAP=1: MEM_DEPTH-1 → 0; WRAP=0: ptr → MEM_DEPTH). Not accepted (WRAP=0, ptr == MEM_DEPTH): NACK, no write, no pulse.
- Repeated start after write allows random read (ptr kept).
- RD: drive bit (sda_oe = ~bit); after 8 bits release for master ACK. ptr+1 with same wrap rule; past end (WRAP=0) returns 8'hFF.
- RD_ACK: master ACK (SDA low at scl_rise) → RD with next byte preloaded; NACK → IGNORE (released).
- Local port: loc_we writes reg[loc_addr] if loc_addr < MEM_DEPTH, otherwise ignored. If I2C write occurs in same cycle to any address, I2C wins, loc write dropped, loc_coll pulses.
- Register width: ptr 8-bit; compare against MEM_DEPTH without truncation.

## Timing
- Reset: state IDLE, ptr 0, all registers 8'h00, sda_oe 0, wr_valid 0, loc_coll 0, busy 0, loc_rdata 8'h00.
- Input latency: pad edge to event = 2 + FILT clk cycles.
- wr_valid asserted the cycle after 8th data bit sampled; reg write in same cycle.
- loc_rdata: 1-cycle latency from loc_addr; reflects same-cycle writes on the following cycle.
- ACK drive: sda_oe asserted 1 cycle after 8th scl_fall, released 1 cycle after 9th scl_fall.
- Reset mid-transfer: bus released next cycle; target ignores bus until next start.

## Test plan
- Write ptr 8'h03, data 8'hA5, 8'h5A → ACKs on all 4 bytes; reg[3]=A5, reg[4]=5A; two wr_valid pulses (addr 3, 4).
- Repeated start, read 2 bytes from ptr 3 with ACK then NACK → SDA returns A5, 5A; released after NACK; stop → busy 0.
- Address 7'h11 → NACK, sda_oe never asserted, no wr_valid.
- WRAP=1, DEPTH=16: write ptr 15, data 11, 22 → reg[15]=11, reg[0]=22. WRAP=0: second byte NACKed, reg[0] unchanged; read past end returns FF.
- Ptr 8'h20 with DEPTH=16 → NACK on pointer byte, no subsequent writes.
- Local write to reg[4] in same cycle as I2C wr_valid → loc_coll pulse, reg holds I2C value; rst asserted mid-read → sda_oe 0 next cycle, all regs 00.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
`timescale 1ns / 1ps
// i2c_slave_regfile: I2C target with a byte register file and a local port.
// SCL/SDA are synchronised and glitch-filtered on clk, bus events drive a
// two-process FSM, and the register file is shared with system logic.
// An I2C write always wins over a same-cycle local write.
module i2c_slave_regfile #(
    parameter logic [6:0] I2C_ADR   = 7'h10,
    parameter int         MEM_DEPTH = 16,
    parameter bit         WRAP      = 1'b1,
    parameter int         FILT      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] loc_addr,
    input  logic [7:0] loc_wdata,
    input  logic       loc_we,
    output logic [7:0] loc_rdata,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       loc_coll,
    output logic       busy
);

    localparam int             AW        = $clog2(MEM_DEPTH);
    localparam int             FCW       = (FILT > 1) ? $clog2(FILT) : 1;
    // Pointer arithmetic is 9 bits wide so that "one past the end" is
    // representable even when MEM_DEPTH is 256.
    localparam logic [8:0]     DEPTH_W   = 9'(MEM_DEPTH);
    localparam logic [8:0]     LAST_W    = 9'(MEM_DEPTH - 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT - 1);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DEV_ADDR = 4'd1,
        ST_DEV_ACK  = 4'd2,
        ST_PTR      = 4'd3,
        ST_PTR_ACK  = 4'd4,
        ST_WR       = 4'd5,
        ST_WR_ACK   = 4'd6,
        ST_RD       = 4'd7,
        ST_RD_ACK   = 4'd8,
        ST_IGNORE   = 4'd9
    } state_t;

    // Advance the pointer after an access; without wrap it parks at MEM_DEPTH.
    function automatic logic [8:0] next_ptr(input logic [8:0] p);
        logic [8:0] n;
        if (p == LAST_W) begin
            n = WRAP ? 9'd0 : DEPTH_W;
        end else begin
            n = p + 9'd1;
        end
        return n;
    endfunction

    // Input conditioning: index 0 = SCL, index 1 = SDA
    logic [1:0]     meta_r;
    logic [1:0]     sync_r;
    logic [1:0]     filt_r;
    logic [1:0]     prev_r;
    logic [FCW-1:0] fcnt_r [2];

    logic scl_rise_s;
    logic scl_fall_s;
    logic sda_rise_s;
    logic sda_fall_s;
    logic start_s;
    logic stop_s;

    // FSM and datapath registers with their next values
    state_t     state_r,    state_nx;
    logic [3:0] bit_cnt_r,  bit_cnt_nx;
    logic [7:0] shift_r,    shift_nx;
    logic [8:0] ptr_r,      ptr_nx;
    logic       rw_r,       rw_nx;
    logic       ack_r,      ack_nx;
    logic       sda_oe_r,   sda_oe_nx;
    logic       busy_r,     busy_nx;
    logic       wr_valid_r, wr_valid_nx;
    logic [7:0] wr_addr_r,  wr_addr_nx;
    logic [7:0] wr_data_r,  wr_data_nx;

    logic [7:0] mem_r [MEM_DEPTH];
    logic [7:0] loc_rdata_r;
    logic       loc_coll_r;

    logic [7:0] rx_byte_s;
    logic       ptr_in_range_s;
    logic [7:0] rd_data_s;
    logic [8:0] rd_ptr_nx_s;
    logic       mem_we_s;
    logic       loc_in_range_s;
    logic       loc_ok_s;

    // Two-flop synchroniser followed by a FILT-sample stability filter per line
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 2'b11;
            sync_r <= 2'b11;
            filt_r <= 2'b11;
            prev_r <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                fcnt_r[i] <= {FCW{1'b0}};
            end
        end else begin
            meta_r <= {sda_i, scl_i};
            sync_r <= meta_r;
            prev_r <= filt_r;
            for (int i = 0; i < 2; i++) begin
                if (sync_r[i] == filt_r[i]) begin
                    fcnt_r[i] <= {FCW{1'b0}};
                end else if (fcnt_r[i] == FILT_LAST) begin
                    filt_r[i] <= sync_r[i];
                    fcnt_r[i] <= {FCW{1'b0}};
                end else begin
                    fcnt_r[i] <= fcnt_r[i] + FCW'(1);
                end
            end
        end
    end

    // Single-cycle bus events; start/stop need SCL high after this cycle's
    // update, so a simultaneous SCL/SDA fall after reset is not a start.
    always_comb begin
        scl_rise_s = filt_r[0] & ~prev_r[0];
        scl_fall_s = ~filt_r[0] & prev_r[0];
        sda_rise_s = filt_r[1] & ~prev_r[1];
        sda_fall_s = ~filt_r[1] & prev_r[1];
        start_s    = sda_fall_s & filt_r[0];
        stop_s     = sda_rise_s & filt_r[0];
    end

    // Received byte, pointer range and the byte to transmit at the pointer
    always_comb begin
        rx_byte_s      = {shift_r[6:0], filt_r[1]};
        ptr_in_range_s = (ptr_r < DEPTH_W);
        loc_in_range_s = ({1'b0, loc_addr} < DEPTH_W);
        loc_ok_s       = loc_we & loc_in_range_s;
        if (ptr_in_range_s) begin
            rd_data_s   = mem_r[ptr_r[AW-1:0]];
            rd_ptr_nx_s = next_ptr(ptr_r);
        end else begin
            rd_data_s   = 8'hFF;
            rd_ptr_nx_s = ptr_r;
        end
    end

    // Protocol FSM: next state, datapath updates and SDA drive decisions
    always_comb begin
        state_nx    = state_r;
        bit_cnt_nx  = bit_cnt_r;
        shift_nx    = shift_r;
        ptr_nx      = ptr_r;
        rw_nx       = rw_r;
        ack_nx      = ack_r;
        sda_oe_nx   = sda_oe_r;
        busy_nx     = busy_r;
        wr_valid_nx = 1'b0;
        wr_addr_nx  = wr_addr_r;
        wr_data_nx  = wr_data_r;
        mem_we_s    = 1'b0;

        if (start_s) begin
            state_nx   = ST_DEV_ADDR;
            bit_cnt_nx = 4'd0;
            sda_oe_nx  = 1'b0;
            busy_nx    = 1'b0;
        end else if (stop_s) begin
            state_nx  = ST_IDLE;
            sda_oe_nx = 1'b0;
            busy_nx   = 1'b0;
        end else begin
            case (state_r)
                ST_DEV_ADDR, ST_PTR, ST_WR: begin
                    if (scl_rise_s) begin
                        shift_nx   = rx_byte_s;
                        bit_cnt_nx = bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd7) begin
                            case (state_r)
                                ST_DEV_ADDR: begin
                                    ack_nx = (rx_byte_s[7:1] == I2C_ADR);
                                    rw_nx  = rx_byte_s[0];
                                end
                                ST_PTR: begin
                                    ack_nx = ({1'b0, rx_byte_s} < DEPTH_W);
                                    if (ack_nx) begin
                                        ptr_nx = {1'b0, rx_byte_s};
                                    end else begin
                                        ptr_nx = ptr_r;
                                    end
                                end
                                ST_WR: begin
                                    ack_nx = ptr_in_range_s;
                                    if (ptr_in_range_s) begin
                                        mem_we_s    = 1'b1;
                                        wr_valid_nx = 1'b1;
                                        wr_addr_nx  = ptr_r[7:0];
                                        wr_data_nx  = rx_byte_s;
                                        ptr_nx      = next_ptr(ptr_r);
                                    end else begin
                                        mem_we_s = 1'b0;
                                    end
                                end
                                default: begin
                                    ack_nx = 1'b0;
                                end
                            endcase
                        end else begin
                            ack_nx = ack_r;
                        end
                    end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
                        bit_cnt_nx = 4'd0;
                        if (ack_r) begin
                            sda_oe_nx = 1'b1;
                            case (state_r)
                                ST_DEV_ADDR: begin
                                    state_nx = ST_DEV_ACK;
                                    busy_nx  = 1'b1;
                                end
                                ST_PTR:  state_nx = ST_PTR_ACK;
                                default: state_nx = ST_WR_ACK;
                            endcase
                        end else begin
                            sda_oe_nx = 1'b0;
                            state_nx  = ST_IGNORE;
                        end
                    end else begin
                        bit_cnt_nx = bit_cnt_r;
                    end
                end
                ST_DEV_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    if (scl_fall_s) begin
                        bit_cnt_nx = 4'd0;
                        if ((state_r == ST_DEV_ACK) && rw_r) begin
                            state_nx  = ST_RD;
                            shift_nx  = rd_data_s;
                            sda_oe_nx = ~rd_data_s[7];
                            ptr_nx    = rd_ptr_nx_s;
                        end else if (state_r == ST_DEV_ACK) begin
                            state_nx  = ST_PTR;
                            sda_oe_nx = 1'b0;
                        end else begin
                            state_nx  = ST_WR;
                            sda_oe_nx = 1'b0;
                        end
                    end else begin
                        state_nx = state_r;
                    end
                end
                ST_RD: begin
                    if (scl_rise_s) begin
                        bit_cnt_nx = bit_cnt_r + 4'd1;
                    end else if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd8) begin
                            state_nx   = ST_RD_ACK;
                            sda_oe_nx  = 1'b0;
                            bit_cnt_nx = 4'd0;
                        end else begin
                            shift_nx  = {shift_r[6:0], 1'b0};
                            sda_oe_nx = ~shift_r[6];
                        end
                    end else begin
                        bit_cnt_nx = bit_cnt_r;
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise_s) begin
                        ack_nx = ~filt_r[1];
                    end else if (scl_fall_s) begin
                        if (ack_r) begin
                            state_nx  = ST_RD;
                            shift_nx  = rd_data_s;
                            sda_oe_nx = ~rd_data_s[7];
                            ptr_nx    = rd_ptr_nx_s;
                        end else begin
                            state_nx  = ST_IGNORE;
                            sda_oe_nx = 1'b0;
                        end
                    end else begin
                        ack_nx = ack_r;
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    state_nx = state_r;
                end
                default: begin
                    state_nx  = ST_IDLE;
                    sda_oe_nx = 1'b0;
                end
            endcase
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'h00;
            ptr_r      <= 9'd0;
            rw_r       <= 1'b0;
            ack_r      <= 1'b0;
            sda_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            wr_valid_r <= 1'b0;
            wr_addr_r  <= 8'h00;
            wr_data_r  <= 8'h00;
        end else begin
            state_r    <= state_nx;
            bit_cnt_r  <= bit_cnt_nx;
            shift_r    <= shift_nx;
            ptr_r      <= ptr_nx;
            rw_r       <= rw_nx;
            ack_r      <= ack_nx;
            sda_oe_r   <= sda_oe_nx;
            busy_r     <= busy_nx;
            wr_valid_r <= wr_valid_nx;
            wr_addr_r  <= wr_addr_nx;
            wr_data_r  <= wr_data_nx;
        end
    end

    // Register file: an I2C write takes priority over the local port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (mem_we_s) begin
            mem_r[ptr_r[AW-1:0]] <= rx_byte_s;
        end else if (loc_ok_s) begin
            mem_r[loc_addr[AW-1:0]] <= loc_wdata;
        end
    end

    // Local read port and collision flag
    always_ff @(posedge clk) begin
        if (rst) begin
            loc_rdata_r <= 8'h00;
            loc_coll_r  <= 1'b0;
        end else begin
            loc_rdata_r <= loc_in_range_s ? mem_r[loc_addr[AW-1:0]] : 8'h00;
            loc_coll_r  <= loc_we & mem_we_s;
        end
    end

    assign sda_oe    = sda_oe_r;
    assign busy      = busy_r;
    assign wr_valid  = wr_valid_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign loc_rdata = loc_rdata_r;
    assign loc_coll  = loc_coll_r;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
`timescale 1ns / 1ps
// Directed bench: a bit-banged I2C master drives two targets on one bus
// (address 7'h10 with wrap, address 7'h20 without wrap).
module tb_i2c_slave_regfile;

    localparam int Q = 80;   // quarter SCL period in ns (SCL period = 32 clk)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic [7:0] loc_addr = 8'h00;
    logic [7:0] loc_wdata = 8'h00;
    logic       loc_we = 1'b0;

    logic       oe0, wv0, coll0, busy0;
    logic [7:0] rdata0, wa0, wd0;
    logic       oe1, wv1, coll1, busy1;
    logic [7:0] rdata1, wa1, wd1;

    int tests = 0;
    int fails = 0;
    int wr_n = 0;
    int coll_n = 0;
    int oe_n = 0;
    logic [7:0] wr_a_q[$];
    logic [7:0] wr_d_q[$];

    typedef struct packed {
        logic       we;
        logic [7:0] waddr;
        logic [7:0] wdata;
        logic [7:0] raddr;
        logic [7:0] exp;
    } loc_vec_t;
    loc_vec_t lv[6];

    assign sda_bus = sda_m & ~oe0 & ~oe1;

    always #5 clk = ~clk;

    i2c_slave_regfile #(.I2C_ADR(7'h10), .MEM_DEPTH(16), .WRAP(1'b1), .FILT(2)) dut0 (
        .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_bus), .sda_oe(oe0),
        .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_we(loc_we),
        .loc_rdata(rdata0), .wr_valid(wv0), .wr_addr(wa0), .wr_data(wd0),
        .loc_coll(coll0), .busy(busy0)
    );

    i2c_slave_regfile #(.I2C_ADR(7'h20), .MEM_DEPTH(16), .WRAP(1'b0), .FILT(2)) dut1 (
        .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_bus), .sda_oe(oe1),
        .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_we(1'b0),
        .loc_rdata(rdata1), .wr_valid(wv1), .wr_addr(wa1), .wr_data(wd1),
        .loc_coll(coll1), .busy(busy1)
    );

    // Record write pulses, collisions and SDA drive cycles of the first target
    always @(negedge clk) begin
        if (wv0) begin
            wr_a_q.push_back(wa0);
            wr_d_q.push_back(wd0);
            wr_n++;
        end
        if (coll0) coll_n++;
        if (oe0) oe_n++;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #(Q);
        scl = 1'b1;   #(Q);
        sda_m = 1'b0; #(Q);
        scl = 1'b0;   #(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #(Q);
        scl = 1'b1;   #(Q);
        sda_m = 1'b1; #(2*Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #(Q);
        scl = 1'b1; #(2*Q);
        scl = 1'b0; #(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #(Q);
        scl = 1'b1;   #(Q);
        b = sda_bus;  #(Q);
        scl = 1'b0;   #(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(mack ? 1'b0 : 1'b1);
    endtask

    task automatic loc_read(input logic [7:0] a, output logic [7:0] d0, output logic [7:0] d1);
        @(negedge clk);
        loc_addr = a;
        @(posedge clk);
        #1;
        d0 = rdata0;
        d1 = rdata1;
    endtask

    // Hang guard
    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack, b, seen;
        logic [7:0] d, d1;
        int         wb, cb, ob;

        lv[0] = '{1'b1, 8'h01, 8'h3C, 8'h01, 8'h3C};
        lv[1] = '{1'b1, 8'h02, 8'hC3, 8'h02, 8'hC3};
        lv[2] = '{1'b1, 8'h12, 8'h77, 8'h02, 8'hC3};   // out of range: no alias onto 2
        lv[3] = '{1'b1, 8'h0F, 8'h99, 8'h0F, 8'h99};
        lv[4] = '{1'b0, 8'h0F, 8'h55, 8'h01, 8'h3C};   // no strobe: nothing written
        lv[5] = '{1'b1, 8'h0F, 8'h00, 8'h0F, 8'h00};

        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("rst_sda_oe", {7'd0, oe0}, 8'd0);
        check("rst_wr_valid", {7'd0, wv0}, 8'd0);
        check("rst_loc_coll", {7'd0, coll0}, 8'd0);
        check("rst_busy", {7'd0, busy0}, 8'd0);
        check("rst_loc_rdata", rdata0, 8'h00);

        // Local port vectors
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            loc_we = lv[i].we;
            loc_addr = lv[i].waddr;
            loc_wdata = lv[i].wdata;
            @(posedge clk);
            #1;
            loc_we = 1'b0;
            loc_addr = lv[i].raddr;
            @(posedge clk);
            #1;
            check($sformatf("loc_vec%0d", i), rdata0, lv[i].exp);
        end

        // Write ptr 3, A5, 5A
        wb = wr_n;
        i2c_start();
        write_byte(8'h20, ack); check("wr_dev_ack", {7'd0, ack}, 8'd1);
        check("busy_after_ack", {7'd0, busy0}, 8'd1);
        write_byte(8'h03, ack); check("wr_ptr_ack", {7'd0, ack}, 8'd1);
        write_byte(8'hA5, ack); check("wr_d0_ack", {7'd0, ack}, 8'd1);
        write_byte(8'h5A, ack); check("wr_d1_ack", {7'd0, ack}, 8'd1);
        i2c_stop();
        check("wr_busy_after_stop", {7'd0, busy0}, 8'd0);
        check("wr_pulse_count", 8'(wr_n - wb), 8'd2);
        check("wr_pulse0_addr", wr_a_q[wb], 8'h03);
        check("wr_pulse0_data", wr_d_q[wb], 8'hA5);
        check("wr_pulse1_addr", wr_a_q[wb+1], 8'h04);
        check("wr_pulse1_data", wr_d_q[wb+1], 8'h5A);
        loc_read(8'h03, d, d1); check("reg3", d, 8'hA5);
        loc_read(8'h04, d, d1); check("reg4", d, 8'h5A);

        // Random read from 3: ACK then NACK
        i2c_start();
        write_byte(8'h20, ack); check("rd_dev_w_ack", {7'd0, ack}, 8'd1);
        write_byte(8'h03, ack); check("rd_ptr_ack", {7'd0, ack}, 8'd1);
        i2c_start();
        write_byte(8'h21, ack); check("rd_dev_r_ack", {7'd0, ack}, 8'd1);
        read_byte(1'b1, d); check("rd_byte0", d, 8'hA5);
        read_byte(1'b0, d); check("rd_byte1", d, 8'h5A);
        check("rd_released", {7'd0, oe0}, 8'd0);
        check("rd_busy_before_stop", {7'd0, busy0}, 8'd1);
        i2c_stop();
        check("rd_busy_after_stop", {7'd0, busy0}, 8'd0);

        // Foreign address 7'h11
        wb = wr_n; ob = oe_n;
        i2c_start();
        write_byte(8'h22, ack); check("bad_addr_nack", {7'd0, ack}, 8'd0);
        write_byte(8'h00, ack); check("bad_addr_data_nack", {7'd0, ack}, 8'd0);
        i2c_stop();
        check("bad_addr_no_drive", 8'(oe_n - ob), 8'd0);
        check("bad_addr_no_write", 8'(wr_n - wb), 8'd0);

        // Wrap at the end (first target)
        i2c_start();
        write_byte(8'h20, ack);
        write_byte(8'h0F, ack); check("wrap_ptr_ack", {7'd0, ack}, 8'd1);
        write_byte(8'h11, ack); check("wrap_d0_ack", {7'd0, ack}, 8'd1);
        write_byte(8'h22, ack); check("wrap_d1_ack", {7'd0, ack}, 8'd1);
        i2c_stop();
        loc_read(8'h0F, d, d1); check("wrap_reg15", d, 8'h11);
        loc_read(8'h00, d, d1); check("wrap_reg0", d, 8'h22);

        // No wrap (second target): second byte refused, read past end gives FF
        i2c_start();
        write_byte(8'h40, ack); check("nowrap_dev_ack", {7'd0, ack}, 8'd1);
        write_byte(8'h0F, ack); check("nowrap_ptr_ack", {7'd0, ack}, 8'd1);
        write_byte(8'h11, ack); check("nowrap_d0_ack", {7'd0, ack}, 8'd1);
        write_byte(8'h22, ack); check("nowrap_d1_nack", {7'd0, ack}, 8'd0);
        i2c_stop();
        loc_read(8'h0F, d, d1); check("nowrap_reg15", d1, 8'h11);
        loc_read(8'h00, d, d1); check("nowrap_reg0", d1, 8'h00);
        i2c_start();
        write_byte(8'h41, ack); check("nowrap_rd_ack", {7'd0, ack}, 8'd1);
        read_byte(1'b0, d); check("nowrap_rd_past_end", d, 8'hFF);
        i2c_stop();

        // Pointer out of range
        wb = wr_n;
        i2c_start();
        write_byte(8'h20, ack);
        write_byte(8'h20, ack); check("bad_ptr_nack", {7'd0, ack}, 8'd0);
        write_byte(8'h77, ack); check("bad_ptr_data_nack", {7'd0, ack}, 8'd0);
        i2c_stop();
        check("bad_ptr_no_write", 8'(wr_n - wb), 8'd0);

        // Local write colliding with an I2C write to reg 4
        wb = wr_n; cb = coll_n; seen = 1'b0;
        i2c_start();
        write_byte(8'h20, ack);
        write_byte(8'h04, ack);
        fork
            begin
                write_byte(8'hC7, ack);
            end
            begin
                loc_addr = 8'h04;
                loc_wdata = 8'h3E;
                loc_we = 1'b1;
                for (int k = 0; k < 600 && !seen; k++) begin
                    @(posedge clk);
                    #1;
                    if (wv0) seen = 1'b1;
                end
                loc_we = 1'b0;
            end
        join
        i2c_stop();
        check("coll_wr_seen", {7'd0, seen}, 8'd1);
        check("coll_pulse_count", 8'(coll_n - cb), 8'd1);
        check("coll_wr_data", wr_d_q[wb], 8'hC7);
        loc_read(8'h04, d, d1); check("coll_reg4", d, 8'hC7);

        // Reset in the middle of a read of reg 5 (00: target drives every bit low)
        i2c_start();
        write_byte(8'h21, ack); check("rstrd_dev_ack", {7'd0, ack}, 8'd1);
        for (int i = 0; i < 3; i++) read_bit(b);
        check("rstrd_driving", {7'd0, oe0}, 8'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstrd_released", {7'd0, oe0}, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int a = 0; a < 16; a++) begin
            loc_read(8'(a), d, d1);
            check($sformatf("rst_reg%0d", a), d, 8'h00);
        end
        i2c_stop();
        i2c_start();
        write_byte(8'h20, ack); check("post_rst_dev_ack", {7'd0, ack}, 8'd1);
        write_byte(8'h01, ack);
        write_byte(8'h5C, ack); check("post_rst_data_ack", {7'd0, ack}, 8'd1);
        i2c_stop();
        loc_read(8'h01, d, d1); check("post_rst_reg1", d, 8'h5C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
